// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, ROM strobes, 1/2-byte assembly, JMP/LDO resolution (option: FETCH_HALT_RESUME_EN)
module fetch_unit (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] rom_addr,
  output logic       rom_read,
  output logic       rom_ena,
  input  logic [7:0] rom_data,
  output logic       ir_valid,
  input  logic       ir_ready,
  output logic [3:0] ir_op,
  output logic [3:0] ir_reg,
  output logic [7:0] ir_imm,
  output logic       ir_long,
  output logic [7:0] pc,
`ifdef FETCH_HALT_RESUME_EN
  input  logic       resume,
`endif
  output logic       halted
);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDO = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_STO = 4'h5;
  localparam logic [3:0] OP_JMP = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_OPND,
    S_LDDATA,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_pc;
  logic [3:0] r_op;
  logic [3:0] r_reg;
  logic [7:0] r_imm;
  logic       r_long;
  logic [3:0] w_fetch_op;
  logic       w_fetch_long;
  logic       w_rom_on;

  assign w_fetch_op   = rom_data[7:4];
  assign w_fetch_long = (w_fetch_op == OP_LDO) || (w_fetch_op == OP_LDA) ||
                        (w_fetch_op == OP_STO) || (w_fetch_op == OP_JMP);

  // State register; reset aborts any partially assembled instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Next-state decode and ROM/handshake outputs
  always_comb begin
    w_next   = r_state;
    w_rom_on = 1'b0;
    rom_addr = r_pc;
    ir_valid = 1'b0;
    halted   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_rom_on = 1'b1;
        if (w_fetch_op == OP_NOP) w_next = S_FETCH;
        else if (w_fetch_long)    w_next = S_OPND;
        else                      w_next = S_ISSUE;
      end
      S_OPND: begin
        w_rom_on = 1'b1;
        if (r_op == OP_JMP)      w_next = S_FETCH;
        else if (r_op == OP_LDO) w_next = S_LDDATA;
        else                     w_next = S_ISSUE;
      end
      S_LDDATA: begin
        // LDO data word lives at the address carried by the operand byte
        w_rom_on = 1'b1;
        rom_addr = r_imm;
        w_next   = S_ISSUE;
      end
      S_ISSUE: begin
        ir_valid = 1'b1;
        if (ir_ready) w_next = (r_op == OP_HLT) ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
`ifdef FETCH_HALT_RESUME_EN
        if (resume) w_next = S_FETCH;
`endif
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign rom_ena  = w_rom_on;
  assign rom_read = w_rom_on;

  // Instruction register and PC; rom_data is only sampled in ROM-enabled states
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc   <= 8'h00;
      r_op   <= 4'h0;
      r_reg  <= 4'h0;
      r_imm  <= 8'h00;
      r_long <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_op   <= rom_data[7:4];
          r_reg  <= rom_data[3:0];
          r_imm  <= 8'h00;
          r_long <= 1'b0;
          r_pc   <= r_pc + 8'd1;
        end
        S_OPND: begin
          r_imm  <= rom_data;
          r_long <= 1'b1;
          r_pc   <= (r_op == OP_JMP) ? rom_data : (r_pc + 8'd1);
        end
        S_LDDATA: r_imm <= rom_data;
        default: ;
      endcase
    end
  end

  assign pc      = r_pc;
  assign ir_op   = r_op;
  assign ir_reg  = r_reg;
  assign ir_imm  = r_imm;
  assign ir_long = r_long;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic       clk;
  logic       rst_n;
  logic [7:0] rom_addr;
  logic       rom_read;
  logic       rom_ena;
  logic [7:0] rom_data;
  logic       ir_valid;
  logic       ir_ready;
  logic [3:0] ir_op;
  logic [3:0] ir_reg;
  logic [7:0] ir_imm;
  logic       ir_long;
  logic [7:0] pc;
  logic       halted;
`ifdef FETCH_HALT_RESUME_EN
  logic       resume;
`endif

  logic [7:0] rom [256];
  int         n_checks;
  int         n_errors;

  // Junk value while disabled so any sample taken with rom_ena=0 corrupts results
  assign rom_data = rom_ena ? rom[rom_addr] : 8'hA5;

  fetch_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rom_addr (rom_addr),
    .rom_read (rom_read),
    .rom_ena  (rom_ena),
    .rom_data (rom_data),
    .ir_valid (ir_valid),
    .ir_ready (ir_ready),
    .ir_op    (ir_op),
    .ir_reg   (ir_reg),
    .ir_imm   (ir_imm),
    .ir_long  (ir_long),
    .pc       (pc),
`ifdef FETCH_HALT_RESUME_EN
    .resume   (resume),
`endif
    .halted   (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!ir_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic clear_rom;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  initial begin
    int  n;
    logic seen_valid;
    logic pc_moved;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    ir_ready = 1'b1;
`ifdef FETCH_HALT_RESUME_EN
    resume   = 1'b0;
`endif
    clear_rom();
    rom[0]  = 8'h00;  rom[1]  = 8'h11;  rom[2]  = 8'h41;  rom[3]  = 8'h62;
    rom[4]  = 8'hE0;  rom[5]  = 8'h13;  rom[19] = 8'hE0;  rom[20] = 8'h21;
    rom[21] = 8'hF0;  rom[22] = 8'h37;  rom[33] = 8'h41;  rom[34] = 8'hE0;
    rom[35] = 8'h15;  rom[65] = 8'h25;

    @(negedge clk);
    check("rst_valid", ir_valid, 0);
    check("rst_op", ir_op, 0);
    check("rst_reg", ir_reg, 0);
    check("rst_imm", ir_imm, 0);
    check("rst_long", ir_long, 0);
    check("rst_halted", halted, 0);
    check("rst_pc", pc, 0);
    check("rst_ena", rom_ena, 1);
    check("rst_read", rom_read, 1);
    check("rst_addr", rom_addr, 0);
    rst_n = 1'b1;

    // NOP at 0 is skipped
    @(negedge clk);
    check("nop_pc", pc, 1);
    check("nop_valid", ir_valid, 0);

    // LDO r1, [0x41] -> data 0x25
    wait_valid(n);
    check("ldo_lat", n, 3);
    check("ldo_op", ir_op, 1);
    check("ldo_reg", ir_reg, 1);
    check("ldo_imm", ir_imm, 8'h25);
    check("ldo_long", ir_long, 1);
    check("ldo_pc", pc, 3);
    @(negedge clk);
    check("ldo_acc", ir_valid, 0);
    ir_ready = 1'b0;

    // ADD s2 under backpressure
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", ir_valid, 1);
      check("bp_op", ir_op, 6);
      check("bp_reg", ir_reg, 2);
      check("bp_long", ir_long, 0);
      check("bp_imm", ir_imm, 0);
      check("bp_pc", pc, 4);
      check("bp_ena", rom_ena, 0);
      @(negedge clk);
    end
    ir_ready = 1'b1;
    @(negedge clk);
    check("bp_acc", ir_valid, 0);

    // JMP 19 -> JMP 33 -> short 0x41, no issue for either JMP
    wait_valid(n);
    check("jmp_lat", n, 5);
    check("jmp_op", ir_op, 4);
    check("jmp_reg", ir_reg, 1);
    check("jmp_long", ir_long, 0);
    check("jmp_pc", pc, 34);
    @(negedge clk);

    // JMP 21 -> HLT
    wait_valid(n);
    check("hlt_lat", n, 3);
    check("hlt_op", ir_op, 4'hF);
    check("hlt_pc", pc, 22);
    @(negedge clk);
    check("hlt_halted", halted, 1);
    check("hlt_valid", ir_valid, 0);
    check("hlt_ena", rom_ena, 0);
    check("hlt_read", rom_read, 0);
    seen_valid = 1'b0;
    pc_moved   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ir_valid) seen_valid = 1'b1;
      if (pc != 8'd22) pc_moved = 1'b1;
    end
    check("hlt_novalid", seen_valid, 0);
    check("hlt_pcheld", pc_moved, 0);
    check("hlt_still", halted, 1);

`ifdef FETCH_HALT_RESUME_EN
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    check("res_halted", halted, 0);
    check("res_addr", rom_addr, 22);
    wait_valid(n);
    check("res_lat", n, 1);
    check("res_op", ir_op, 3);
    check("res_reg", ir_reg, 7);
    check("res_pc", pc, 23);
    @(negedge clk);
`endif

    // Second image: JMP FF at 0; STO r2 at FF with operand wrapping to 00
    rst_n = 1'b0;
    clear_rom();
    rom[0]   = 8'hE0;
    rom[1]   = 8'hFF;
    rom[255] = 8'h52;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("opnd_addr", rom_addr, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_pc", pc, 0);
    check("mid_valid", ir_valid, 0);
    check("mid_op", ir_op, 0);
    check("mid_addr", rom_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("restart_addr", rom_addr, 0);
    wait_valid(n);
    check("wrap_lat", n, 4);
    check("wrap_op", ir_op, 5);
    check("wrap_reg", ir_reg, 2);
    check("wrap_imm", ir_imm, 8'hE0);
    check("wrap_long", ir_long, 1);
    check("wrap_pc", pc, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 8-bit RISC CPU. It sits directly upstream of the decode/execute logic and directly downstream of the instruction ROM. It owns the program counter and drives the ROM's `addr`/`read`/`ena` inputs. It assembles one- and two-byte instructions, resolves `JMP` and `LDO` locally, and hands each completed instruction to execute over a valid/ready handshake.

## Interface
- Parameters: none (8-bit address and data fixed by the ISA).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rom_addr` out 8: ROM address.
- `rom_read` out 1: ROM read strobe.
- `rom_ena` out 1: ROM enable.
- `rom_data` in 8: ROM output; combinational from `rom_addr`; `8'hzz` when not enabled.
- `ir_valid` out 1: issued instruction is valid.
- `ir_ready` in 1: execute accepts the instruction.
- `ir_op` out 4: opcode, taken from instruction bits [7:4].
- `ir_reg` out 4: register field, taken from instruction bits [3:0].
- `ir_imm` out 8: second byte; for `LDO`, the ROM data word instead.
- `ir_long` out 1: instruction was two bytes.
- `pc` out 8: address of the next byte to fetch.
- `halted` out 1: fetch stopped on `HLT`.
- `resume` in 1: present only with `FETCH_HALT_RESUME_EN`.

## Operation
- Opcodes:
  - Long (two-byte): `LDO`=1, `LDA`=2, `STO`=5, `JMP`=E.
  - Special: `NOP`=0, `HLT`=F.
  - All others are short (one byte).
- States: `FETCH`, `OPND`, `LDDATA`, `ISSUE`, `HALT`.
- `FETCH`: `rom_addr`=`pc`.
  - Latch `rom_data` into IR; `pc`<=`pc`+1.
  - `NOP` → stay in `FETCH`; not issued.
  - Long opcode → `OPND`.
  - Otherwise → `ISSUE`, with `ir_long`=0 and `ir_imm`=0.
- `OPND`: `rom_addr`=`pc`.
  - Latch `rom_data` into `ir_imm`; `pc`<=`pc`+1.
  - `JMP` → `pc`<=operand, then `FETCH`; `JMP` is never issued.
  - `LDO` → `LDDATA`.
  - Otherwise → `ISSUE`, with `ir_long`=1.
- `LDDATA`: `rom_addr`=`ir_imm`.
  - Latch `rom_data` into `ir_imm`; `pc` unchanged.
  - → `ISSUE`.
- `ISSUE`: `ir_valid`=1.
  - `ir_*` held stable until `ir_valid && ir_ready`.
  - On accept: `HLT` → `HALT`, otherwise → `FETCH`.
- `HALT`: `halted`=1, `ir_valid`=0, `pc` frozen.
- ROM strobes: `rom_ena` = `rom_read` = 1 in `FETCH`/`OPND`/`LDDATA`, 0 otherwise.
  - In `ISSUE`/`HALT`, `rom_addr` holds `pc`.
- `pc` arithmetic is modulo 256: 8'hFF+1 → 8'h00. Operand fetch at `pc`=FF reads address 00.
- `rom_data` is never sampled while `rom_ena`=0.

## Timing
- Reset (async assert, sync-released state):
  - state=`FETCH`, `pc`=0.
  - `ir_valid`=0, `ir_op`=0, `ir_reg`=0, `ir_imm`=0, `ir_long`=0, `halted`=0.
  - `rom_ena`=`rom_read`=1 and `rom_addr`=0, since the state is `FETCH`.
- ROM is combinational; data is sampled on the same edge that ends the address cycle.
- Latency from entering `FETCH` to `ir_valid`:
  - Short: 1 cycle.
  - Long: 2 cycles.
  - `LDO`: 3 cycles.
- `JMP` costs 2 cycles with no issue.
- Minimum issue interval is 2 cycles for short instructions (the `ISSUE` cycle plus the next `FETCH`).
- Backpressure: with `ir_ready`=0, stay in `ISSUE` indefinitely. `ir_*` and `pc` do not change; ROM is disabled.
- `ir_ready` is ignored outside `ISSUE`.
- `rst_n` low in any state, including `OPND` and `LDDATA`, aborts immediately to the reset values; any partial instruction is discarded.

## Configuration
- `FETCH_HALT_RESUME_EN`:
  - Defined: adds the `resume` input. In `HALT`, `resume`=1 for one cycle → `FETCH` at the current `pc` (the byte after `HLT`), and `halted` clears on that edge. `resume` is ignored in all other states.
  - Undefined: no `resume` port; `HALT` exits only via `rst_n`.

## Test plan
- ROM image with byte 1 = 8'h11 and byte 2 = 8'h41, and ROM[65]=37, `ir_ready`=1 → `ir_valid` 3 cycles after reaching `pc`=1, with `ir_op`=1, `ir_reg`=1, `ir_imm`=8'h25, `ir_long`=1, `pc`=3.
- ROM[19]=8'hE0, ROM[20]=8'h21, ROM[33]=8'h41 → no issue for the `JMP`; the next issued instruction has `ir_op`=4, `ir_reg`=1, `ir_long`=0, and `pc`=34 after its fetch.
- ROM[21]=8'hF0 → `HLT` issued once; after accept, `halted`=1 and `rom_ena`=0. `pc`=22 is held for 20 cycles; no further `ir_valid`.
- `ir_ready` held 0 for 5 cycles during an issued `ADD s2` (8'h62) → `ir_valid`=1 and `ir_op`=6/`ir_reg`=2 stable throughout; accepted on the cycle `ir_ready` rises.
- `rst_n` pulsed low mid-`OPND` → `pc`=0 and `ir_valid`=0 immediately; after release, fetch restarts at address 0.
- `NOP` at address 0, and a long opcode at FF followed by its operand at 00 → `NOP` not issued; the operand is read from address 00 (wrap). With `FETCH_HALT_RESUME_EN` defined, a `resume` pulse in `HALT` refetches at `HLT`+1.
